instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage sitting directly upstream of Main_Decoder. Owns the PC register,
//  fetches each instruction word from instruction memory over a req/rvalid handshake,
//  holds it until the core acknowledges execution, then selects the next PC.
//  Next PC is PC+4, or PCTarget when PCSrc = Branch&Zero | Jump.
//  Drives op[6:0] straight into Main_Decoder.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; must be word aligned
//  NOP_INSTR  32'h0000_0013  instr value while no valid word is held (addi x0,x0,0)
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  reset        in   1   synchronous, active-high reset
//  imem_req     out  1   one-cycle pulse: read instruction word at imem_addr
//  imem_addr    out  32  byte address of the fetch; equals pc
//  imem_rvalid  in   1   imem_rdata valid this cycle; latency >= 1 cycle after imem_req
//  imem_rdata   in   32  instruction word returned by instruction memory
//  instr_valid  out  1   instr/op/pc hold a fetched, not-yet-acknowledged instruction
//  instr        out  32  current instruction word (NOP_INSTR when !instr_valid)
//  op           out  7   instr[6:0], feeds Main_Decoder op input
//  pc           out  32  address of current instruction
//  pc_plus4     out  32  pc + 4, for the JAL link value (ResultSrc=2'b10)
//  instr_ack    in   1   core has executed instr this cycle; advance PC
//  PCSrc        in   1   take PCTarget instead of pc+4; sampled only on accepted ack
//  PCTarget     in   32  branch/jump target from the target adder
//  fetch_err    out  1   sticky: misaligned target taken; fetching halted
// BEHAVIOUR
//  Reset (sync, active-high): state=S_BOOT, pc=RESET_PC, instr=NOP_INSTR, instr_valid=0,
//   imem_req=0, fetch_err=0. imem_addr=pc throughout. op=instr[6:0] combinationally.
//  FSM states and transitions:
//   S_BOOT : first cycle out of reset, no request   -> S_REQ
//   S_REQ  : imem_req=1 for exactly this cycle      -> S_WAIT
//   S_WAIT : imem_req=0; on imem_rvalid latch instr=imem_rdata, set instr_valid -> S_HOLD
//   S_HOLD : instr_valid=1, instr/pc stable; on instr_ack:
//            target = PCSrc ? PCTarget : pc+4; pc<=target; instr_valid<=0; instr<=NOP_INSTR;
//            if PCSrc && PCTarget[1:0]!=2'b00 -> fetch_err<=1, S_ERR; else -> S_REQ
//   S_ERR  : imem_req=0, instr_valid=0; held until reset
//  Latency: imem_req in cycle N, rvalid earliest N+1, instr_valid from N+2.
//   Min throughput: one instruction per 3 cycles (REQ, WAIT, HOLD).
//  Handshake rules:
//   - instr_ack ignored when instr_valid=0 (any state other than S_HOLD).
//   - PCSrc/PCTarget ignored unless instr_ack accepted in S_HOLD.
//   - imem_rvalid ignored outside S_WAIT; at most one request outstanding.
//   - Instruction memory shares reset; a response outstanding at reset is dropped
//     by memory, never delivered.
//  Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0, not an error.
//   Only PCSrc-selected targets are alignment checked; pc+4 from aligned pc is aligned.
//  Simultaneous: reset has priority over every other input in the same cycle;
//   instr_ack and reset together -> reset result only, no PC advance.
//  Reset mid-operation (any state): next cycle matches post-reset values above.
// TESTING
//  1 reset 1->0; imem_rdata=32'h0050_0093 one cycle after imem_req -> req at addr 0x0,
//    then instr_valid=1, instr=32'h0050_0093, op=7'b0010011, pc=0x0, pc_plus4=0x4
//  2 ack with PCSrc=0 at pc=0x0 -> instr_valid=0 next cycle, imem_req=1 with
//    imem_addr=0x4, pc_plus4=0x8
//  3 ack with PCSrc=1, PCTarget=0x40 (beq taken) -> next imem_addr=0x40; then
//    ack, PCSrc=1, PCTarget=0x0 (jal) -> imem_addr=0x0
//  4 rvalid delayed 5 cycles -> imem_req high one cycle only, instr_valid=0 and
//    instr=32'h0000_0013 until the cycle after rvalid
//  5 ack with PCSrc=1, PCTarget=0x42 -> fetch_err=1 sticky, imem_req=0 forever;
//    reset -> fetch_err=0, fetch restarts at RESET_PC
//  6 reset during S_HOLD; ack while instr_valid=0; stray rvalid in S_HOLD
//    -> pc=RESET_PC, instr=NOP; ack and rvalid ignored, no pc change

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage ahead of Main_Decoder: owns the PC, fetches one instruction word at a time
// over a req/rvalid handshake and holds it until the core acknowledges execution.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        instr_ack,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        StBoot,
        StReq,
        StWait,
        StHold,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_inc;
    logic [31:0] target;
    logic        ack_taken;
    logic        rsp_taken;
    logic        target_misaligned;

    assign pc_inc            = pc_q + 32'd4;
    assign target            = PCSrc ? PCTarget : pc_inc;
    assign ack_taken         = (state_q == StHold) && instr_ack;
    assign rsp_taken         = (state_q == StWait) && imem_rvalid;
    // Sequential pc+4 from an aligned pc can never be misaligned.
    assign target_misaligned = PCSrc && (PCTarget[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot: state_d = StReq;
            StReq:  state_d = StWait;
            StWait: if (imem_rvalid) state_d = StHold;
            StHold: begin
                if (instr_ack) state_d = target_misaligned ? StErr : StReq;
            end
            StErr:  state_d = StErr;
            default: state_d = StBoot;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if (rsp_taken) begin
            instr_d = imem_rdata;
        end
        if (ack_taken) begin
            pc_d    = target;
            instr_d = NOP_INSTR;
        end
    end

    always_comb begin
        imem_req    = (state_q == StReq);
        instr_valid = (state_q == StHold);
        fetch_err   = (state_q == StErr);
        imem_addr   = pc_q;
        pc          = pc_q;
        pc_plus4    = pc_inc;
        instr       = instr_q;
        op          = instr_q[6:0];
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: a memory responder with random latency,
// a driver that predicts the fetch sequence, and a monitor that checks every DUT cycle.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          N_CYCLES = 4000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_t;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_ack;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        fetch_err;

    instr_fetch_unit #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .op         (op),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instr_ack  (instr_ack),
        .PCSrc      (PCSrc),
        .PCTarget   (PCTarget),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    fetch_t      exp_fetch[$];
    logic [31:0] exp_addr[$];
    logic [31:0] model_pc;
    logic        model_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Memory contents: the boot word is the addi from the bring-up sequence, the rest hashed.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        exp_fetch.delete();
        exp_addr.delete();
        model_pc  = RST_PC;
        model_err = 1'b0;
        exp_addr.push_back(RST_PC);
        exp_fetch.push_back('{pc: RST_PC, word: mem_word(RST_PC)});
    endtask

    task automatic model_ack(input logic src, input logic [31:0] tgt);
        logic [31:0] nxt;
        nxt = src ? tgt : model_pc + 32'd4;
        if (src && (tgt % 4 != 0)) begin
            model_err = 1'b1;
        end else begin
            exp_addr.push_back(nxt);
            exp_fetch.push_back('{pc: nxt, word: mem_word(nxt)});
        end
        model_pc = nxt;
    endtask

    // Memory responder: acts #1 after each rising edge, drops outstanding reads on reset.
    initial begin
        int          cnt;
        int          n_req;
        logic        busy;
        logic [31:0] raddr;
        logic [31:0] r;
        busy        = 1'b0;
        cnt         = 0;
        n_req       = 0;
        raddr       = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (reset) begin
                busy = 1'b0;
            end else if (imem_req) begin
                if (busy) flag_fail("req_while_outstanding");
                if (exp_addr.size() == 0) flag_fail("unexpected_req");
                else check("imem_addr", imem_addr, exp_addr.pop_front());
                busy  = 1'b1;
                raddr = imem_addr;
                cnt   = (n_req == 0) ? 1 : (n_req == 1) ? 5 : $urandom_range(1, 6);
                n_req++;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(raddr);
                    busy        = 1'b0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                r           = $urandom;
                imem_rvalid = 1'b1;
                imem_rdata  = r;
            end
        end
    end

    // Monitor: pops the scoreboard when a new instruction appears, checks holding and idle values.
    initial begin
        logic   prev_valid;
        int     idle;
        fetch_t cur;
        prev_valid = 1'b0;
        idle       = 0;
        cur        = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                check("rst_pc", pc, RST_PC);
                check("rst_instr", instr, NOP);
                check("rst_valid", {31'b0, instr_valid}, 32'd0);
                check("rst_req", {31'b0, imem_req}, 32'd0);
                check("rst_err", {31'b0, fetch_err}, 32'd0);
                prev_valid = 1'b0;
                idle       = 0;
            end else begin
                check("fetch_err", {31'b0, fetch_err}, {31'b0, model_err});
                if (model_err) begin
                    check("req_in_err", {31'b0, imem_req}, 32'd0);
                    check("valid_in_err", {31'b0, instr_valid}, 32'd0);
                end
                if (instr_valid && !prev_valid) begin
                    if (exp_fetch.size() == 0) begin
                        flag_fail("unexpected_instr");
                    end else begin
                        cur = exp_fetch.pop_front();
                        check("instr", instr, cur.word);
                        check("op", {25'b0, op}, {25'b0, cur.word[6:0]});
                        check("pc", pc, cur.pc);
                        check("pc_plus4", pc_plus4, cur.pc + 32'd4);
                    end
                end else if (instr_valid) begin
                    check("instr_held", instr, cur.word);
                    check("pc_held", pc, cur.pc);
                end else begin
                    check("idle_instr", instr, NOP);
                    check("idle_op", {25'b0, op}, {25'b0, NOP[6:0]});
                end
                if (!instr_valid && !model_err) idle++;
                else idle = 0;
                if (idle > 20) begin
                    flag_fail("fetch_stall");
                    idle = 0;
                end
                prev_valid = instr_valid;
            end
        end
    end

    // Driver: decides reset/ack at the falling edge and updates the reference model at once.
    initial begin
        int          acc_idx;
        int          err_wait;
        logic        do_reset;
        logic        valid_now;
        logic        src;
        logic [31:0] tgt;
        logic [31:0] r;
        acc_idx   = 0;
        err_wait  = 0;
        reset     = 1'b1;
        instr_ack = 1'b0;
        PCSrc     = 1'b0;
        PCTarget  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            if (cyc != 0) @(negedge clk);
            valid_now = instr_valid;
            do_reset  = 1'b0;
            if (model_err) begin
                err_wait++;
                if (err_wait >= 8) do_reset = 1'b1;
            end else if (acc_idx >= 4 && $urandom_range(0, 59) == 0) begin
                do_reset = 1'b1;
            end

            r   = $urandom;
            src = r[0];
            case ($urandom_range(0, 9))
                0, 1: begin
                    tgt      = $urandom;
                    tgt[1:0] = 2'($urandom_range(1, 3));
                end
                2:       tgt = 32'hFFFF_FFFC;
                default: begin
                    tgt      = $urandom;
                    tgt[1:0] = 2'b00;
                end
            endcase
            instr_ack = r[1] | r[2];

            if (valid_now && acc_idx < 4 && !do_reset) begin
                instr_ack = 1'b1;
                case (acc_idx)
                    0:       begin src = 1'b0; tgt = 32'h0000_0000; end
                    1:       begin src = 1'b1; tgt = 32'h0000_0040; end
                    2:       begin src = 1'b1; tgt = 32'h0000_0000; end
                    default: begin src = 1'b1; tgt = 32'h0000_0042; end
                endcase
            end
            PCSrc    = src;
            PCTarget = tgt;

            if (do_reset) begin
                reset    = 1'b1;
                err_wait = 0;
                model_reset();
            end else begin
                reset = 1'b0;
                if (valid_now && instr_ack) begin
                    model_ack(src, tgt);
                    acc_idx++;
                end
            end
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
